// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one four-phase GCD datapath among N clients.
// Optional activity counters are compiled in when GCD_ARB_PERF_EN is defined.
module gcd_arbiter #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   cmd_valid,
  output logic [N-1:0]   cmd_ready,
  input  logic [N*W-1:0] cmd_a,
  input  logic [N*W-1:0] cmd_b,
  output logic [N-1:0]   rsp_valid,
  input  logic [N-1:0]   rsp_ready,
  output logic [W-1:0]   rsp_data,
  output logic           busy,
  output logic           gcd_req,
  input  logic           gcd_ack,
  output logic [W-1:0]   gcd_load_val,
  input  logic [W-1:0]   gcd_result
`ifdef GCD_ARB_PERF_EN
  ,
  output logic [31:0]    perf_ops,
  output logic [31:0]    perf_busy
`endif
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_REL_A  = 3'd2;
  localparam logic [2:0] S_LOAD_B = 3'd3;
  localparam logic [2:0] S_REL_R  = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]    r_state;
  logic [LW-1:0] r_last;
  logic [LW-1:0] r_gnt;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_res;
  logic [W-1:0]  r_load_val;
  logic          r_req;

  logic          w_found;
  logic [LW-1:0] w_idx;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic          w_accept;
  logic          w_rsp_done;

  // Search starts just after the last winner, so the winner drops to lowest priority.
  // NOTE: every variable written in always_comb gets a default first; a path that
  // skips the assignment would otherwise infer a latch.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      int probe;
      probe = (int'(r_last) + k) % N;
      if (!w_found && cmd_valid[probe]) begin
        w_found = 1'b1;
        w_idx   = probe[LW-1:0];
      end
    end
  end

  assign w_a        = cmd_a[w_idx*W +: W];
  assign w_b        = cmd_b[w_idx*W +: W];
  assign w_accept   = (r_state == S_IDLE) && w_found && !reset;
  assign w_rsp_done = (r_state == S_RESP) && rsp_ready[r_gnt];

  assign cmd_ready    = w_accept ? (N'(1) << w_idx) : '0;
  assign rsp_valid    = (r_state == S_RESP) ? (N'(1) << r_gnt) : '0;
  assign rsp_data     = r_res;
  assign busy         = (r_state != S_IDLE);
  assign gcd_req      = r_req;
  assign gcd_load_val = r_load_val;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_last     <= LW'(N - 1);
      r_gnt      <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_load_val <= '0;
      r_req      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_gnt  <= w_idx;
            r_last <= w_idx;
            r_b    <= w_b;
            // A zero operand would never terminate the GCD; answer locally.
            if (w_a == '0 || w_b == '0) begin
              r_res   <= w_a | w_b;
              r_state <= S_RESP;
            end else begin
              r_load_val <= w_a;
              r_req      <= 1'b1;
              r_state    <= S_LOAD_A;
            end
          end
        end
        S_LOAD_A: begin
          if (gcd_ack) begin
            r_req      <= 1'b0;
            r_load_val <= r_b;
            r_state    <= S_REL_A;
          end
        end
        S_REL_A: begin
          if (!gcd_ack) begin
            r_req   <= 1'b1;
            r_state <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (gcd_ack) begin
            r_res   <= gcd_result;
            r_req   <= 1'b0;
            r_state <= S_REL_R;
          end
        end
        S_REL_R: begin
          // Waiting for ack to drop leaves the GCD ready for its next a-load.
          if (!gcd_ack) r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_done) r_state <= S_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GCD_ARB_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_ops  <= '0;
      r_perf_busy <= '0;
    end else begin
      if (w_rsp_done) r_perf_ops <= r_perf_ops + 32'd1;
      if (busy)       r_perf_busy <= r_perf_busy + 32'd1;
    end
  end

  assign perf_ops  = r_perf_ops;
  assign perf_busy = r_perf_busy;
`endif

endmodule
